param_reg_bank: RTL
===================

Name: param_reg_bank

Overview:
Parametrised single-clock, dual-port register bank that succeeds the fixed 16x8 dual-clock bank. Both ports A and B can read and write, with registered read data and write-first bypass. The block adds deterministic write-collision arbitration and a hardware clear sequencer that zeroes the array one entry per cycle. It sits beside datapath blocks as a shared scratch/config store.

Parameters:
DATA_W, 8, width of each register in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
RST_VAL, 0, value loaded into every entry on reset and by the clear sequence (DATA_W bits)

Ports:
CLK  input  1  single clock; all state updates on its rising edge
RST_N  input  1  reset, asynchronous, active-low
weA  input  1  port A write enable
addrA  input  ADDR_W  port A address
data_inA  input  DATA_W  port A write data
data_outA  output  DATA_W  port A registered read data
weB  input  1  port B write enable
addrB  input  ADDR_W  port B address
data_inB  input  DATA_W  port B write data
data_outB  output  DATA_W  port B registered read data
clr_req  input  1  request to start the clear sequence (level sampled each cycle)
busy  output  1  high while the clear sequence runs
clr_done  output  1  one-cycle pulse on the last clear write
collision  output  1  one-cycle pulse: both ports wrote the same address in the same cycle
wr_drop  output  1  one-cycle pulse: a write was discarded because busy was high

Behaviour:
- Reset (RST_N=0, asynchronous): all DEPTH entries = RST_VAL; data_outA = data_outB = 0; busy, clr_done, collision, wr_drop = 0; FSM = IDLE; clear pointer = 0.
- Reads: every cycle, data_outX <= value of entry addrX after this cycle's writes (write-first). Read latency is 1 cycle. There is no read enable.
- Write-first bypass applies across ports. If A writes addr k and B reads addr k in the same cycle, data_outB = data_inA on the next cycle. The same holds with A and B swapped.
- Writes: when weX=1 and FSM=IDLE, entry addrX <= data_inX at the edge.
- Collision: weA=weB=1, addrA==addrB, FSM=IDLE:
  - port A wins and B's write is dropped;
  - collision=1 for the next cycle;
  - both data_outs return data_inA.
- Writes to different addresses in the same cycle both commit, with no flag.
- FSM states:
  - IDLE: if clr_req=1, go to CLEAR with pointer=0 and busy=1 from the next cycle.
  - CLEAR: each cycle writes entry[pointer] = RST_VAL and increments pointer.
    - When pointer == DEPTH-1: write it, pulse clr_done for that cycle's output, return to IDLE, busy=0 next cycle, pointer back to 0.
    - The sequence lasts exactly DEPTH cycles with busy high.
- clr_req while busy=1 is ignored and does not restart the sequence. clr_req held high after completion starts a new sequence from IDLE on the next cycle.
- Writes while busy=1 are discarded. wr_drop=1 the next cycle if weA or weB was 1; a single pulse covers both ports. No collision flag is raised during CLEAR.
- Reads while busy=1 are allowed. A read returns the entry's current content, reflecting clear writes already committed, including a clear write to the same address in the same cycle (write-first).
- Asserting reset mid-CLEAR aborts the sequence immediately: all entries = RST_VAL, busy=0, and clr_done is not pulsed.
- Address wrap: addresses are exactly ADDR_W bits, so no out-of-range address exists. The clear pointer is ADDR_W bits and wraps to 0 after DEPTH-1.
- Flags are registered outputs and never combinational from inputs.

Test Plan:
- Reset then read: RST_N low, release, addrA=addrB=0..15 -> data_outA = data_outB = 00 for every address, 1 cycle after each address.
- Basic write/read: A writes addr i = 8'h10+i for i=0..15, then B reads 0..15 -> data_outB = 10..1F with 1-cycle latency; data_outA shows identical values.
- Cross-port bypass: A writes addr 5 = AA while B reads addr 5 in the same cycle -> data_outB = AA next cycle; collision stays 0.
- Collision: weA=weB=1, addr 3, data_inA=11, data_inB=22 -> collision pulses 1 cycle; a later read of addr 3 returns 11 on both ports.
- Clear sequence: fill with non-zero data, pulse clr_req, issue weA to addr 2 during busy -> busy high exactly 16 cycles, clr_done pulses once on the last cycle, wr_drop pulses once, all entries read 00 afterwards.
- Reset mid-clear: start clear, assert RST_N low after 6 cycles -> busy=0 immediately, no clr_done, all entries 00, and a normal write succeeds after release.

Source files
------------

// File: rtl/param_reg_bank.sv
// Dual-port register bank with write-first reads, collision arbitration (port A wins) and a clear sequencer.
// Reads have 1-cycle latency. Writes are never stalled: while a clear runs they are dropped and wr_drop is flagged.
module param_reg_bank #(
    parameter int                 DATA_W  = 8,
    parameter int                 ADDR_W  = 4,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              weA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] data_inA,
    output logic [DATA_W-1:0] data_outA,
    input  logic              weB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] data_inB,
    output logic [DATA_W-1:0] data_outB,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              collision,
    output logic              wr_drop
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_CLEAR = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              idle;
    logic              clearing;
    logic              same_addr;
    logic              wr_a;
    logic              wr_b;
    logic [DATA_W-1:0] nxt_a;
    logic [DATA_W-1:0] nxt_b;

    assign idle      = (state == ST_IDLE);
    assign clearing  = (state == ST_CLEAR);
    assign same_addr = (addrA == addrB);
    assign wr_a      = idle && weA;
    // B loses an address collision, so its write is suppressed outright
    assign wr_b      = idle && weB && !(weA && same_addr);

    assign busy     = clearing;
    assign clr_done = clearing && (ptr == LAST_PTR);

    always_comb begin
        nxt_a = mem[addrA];
        if (wr_b && same_addr) nxt_a = data_inB;
        if (wr_a) nxt_a = data_inA;
        if (clearing && ptr == addrA) nxt_a = RST_VAL;
    end

    always_comb begin
        nxt_b = mem[addrB];
        if (wr_b) nxt_b = data_inB;
        if (wr_a && same_addr) nxt_b = data_inA;
        if (clearing && ptr == addrB) nxt_b = RST_VAL;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
        end else if (clearing) begin
            mem[ptr] <= RST_VAL;
        end else begin
            if (wr_a) mem[addrA] <= data_inA;
            if (wr_b) mem[addrB] <= data_inB;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else if (clearing) begin
            ptr <= ptr + ADDR_W'(1);
            if (ptr == LAST_PTR) state <= ST_IDLE;
        end else if (clr_req) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_outA <= '0;
            data_outB <= '0;
            collision <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            data_outA <= nxt_a;
            data_outB <= nxt_b;
            collision <= idle && weA && weB && same_addr;
            wr_drop   <= clearing && (weA || weB);
        end
    end
endmodule
